// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: operand-forwarding
// selects, mult/div sequencer states and register-number width.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EX    = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_MEMLD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  typedef logic [REG_W-1:0] reg_num_t;

endpackage

// File: rtl/pipe_hazard_ctrl_md_sequencer.sv
// Occupancy tracker for the shared multi-cycle mult/div unit: issues a start
// pulse when an op leaves ID unstalled and holds busy for the op's latency.
module md_sequencer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic clrn,
  input  logic stall,
  input  logic id_is_md,
  input  logic id_is_div,
  output logic md_start,
  output logic md_busy
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stalled op stays in ID; it is launched on the cycle the stall clears.
        md_start = id_is_md & ~stall;
        if (md_start) begin
          cnt_d   = id_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy = (state_q == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall scheduler beside the ID stage: load-use and mult/div
// structural stalls, branch flush, operand forwarding and a stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  reg_num_t        id_rs,
  input  reg_num_t        id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_is_md,
  input  logic            id_is_div,
  input  logic            id_rd_hilo,
  input  logic            id_br_taken,
  input  logic            ex_wreg,
  input  logic            ex_m2reg,
  input  reg_num_t        ex_rd,
  input  logic            mem_wreg,
  input  logic            mem_m2reg,
  input  reg_num_t        mem_rd,
  output logic            stall,
  output logic            id_ex_bubble,
  output logic            if_id_flush,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb,
  output logic            md_start,
  output logic            md_busy,
  output logic [PC_W-1:0] stall_cnt
);

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic lu, sh;

  // An EX load cannot be forwarded yet, so it falls through to MEM or regfile.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                         input logic ex_ld, input logic mem_ld);
    if (hit_ex && !ex_ld)       return FWD_EX;
    else if (hit_mem && mem_ld) return FWD_MEMLD;
    else if (hit_mem)           return FWD_MEM;
    else                        return FWD_RF;
  endfunction

  assign rs_ex  = id_use_rs & ex_wreg  & (ex_rd  != '0) & (ex_rd  == id_rs);
  assign rt_ex  = id_use_rt & ex_wreg  & (ex_rd  != '0) & (ex_rd  == id_rt);
  assign rs_mem = id_use_rs & mem_wreg & (mem_rd != '0) & (mem_rd == id_rs);
  assign rt_mem = id_use_rt & mem_wreg & (mem_rd != '0) & (mem_rd == id_rt);

  assign lu = ex_m2reg & (rs_ex | rt_ex);
  assign sh = md_busy & (id_rd_hilo | id_is_md);

  assign stall        = lu | sh;
  assign id_ex_bubble = stall;
  // A stalled branch is re-evaluated next cycle, so flush waits for the stall to clear.
  assign if_id_flush  = id_br_taken & ~stall;

  assign fwda = fwd_sel(rs_ex, rs_mem, ex_m2reg, mem_m2reg);
  assign fwdb = fwd_sel(rt_ex, rt_mem, ex_m2reg, mem_m2reg);

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .clrn      (clrn),
    .stall     (stall),
    .id_is_md  (id_is_md),
    .id_is_div (id_is_div),
    .md_start  (md_start),
    .md_busy   (md_busy)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + PC_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a remaining-busy-cycles model is
// compared every cycle, and literal expectations pin the key scenarios.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;
  localparam int CNT_W   = 5;
  localparam int PC_W    = 32;
  localparam longint unsigned SC_MAX = (64'd1 << PC_W) - 64'd1;

  logic            clk = 1'b0;
  logic            clrn;
  logic [4:0]      id_rs, id_rt, ex_rd, mem_rd;
  logic            id_use_rs, id_use_rt, id_is_md, id_is_div, id_rd_hilo, id_br_taken;
  logic            ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic            stall, id_ex_bubble, if_id_flush, md_start, md_busy;
  logic [1:0]      fwda, fwdb;
  logic [PC_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W),
    .PC_W    (PC_W)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_md     (id_is_md),
    .id_is_div    (id_is_div),
    .id_rd_hilo   (id_rd_hilo),
    .id_br_taken  (id_br_taken),
    .ex_wreg      (ex_wreg),
    .ex_m2reg     (ex_m2reg),
    .ex_rd        (ex_rd),
    .mem_wreg     (mem_wreg),
    .mem_m2reg    (mem_m2reg),
    .mem_rd       (mem_rd),
    .stall        (stall),
    .id_ex_bubble (id_ex_bubble),
    .if_id_flush  (if_id_flush),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: the unit is simply "busy for N more cycles"; outputs follow from the rules.
  int              busy_left;
  longint unsigned m_sc;
  logic m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem, m_busy, m_stall, m_flush, m_start;
  logic [1:0] m_fwda, m_fwdb;

  function automatic logic [1:0] pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex && !ex_m2reg)       return 2'd1;
    if (hit_mem && mem_m2reg)      return 2'd3;
    if (hit_mem)                   return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    m_rs_ex  = id_use_rs && ex_wreg  && (ex_rd  != 0) && (ex_rd  == id_rs);
    m_rt_ex  = id_use_rt && ex_wreg  && (ex_rd  != 0) && (ex_rd  == id_rt);
    m_rs_mem = id_use_rs && mem_wreg && (mem_rd != 0) && (mem_rd == id_rs);
    m_rt_mem = id_use_rt && mem_wreg && (mem_rd != 0) && (mem_rd == id_rt);
    m_busy   = (busy_left > 0);
    m_stall  = (ex_m2reg && (m_rs_ex || m_rt_ex)) || (m_busy && (id_rd_hilo || id_is_md));
    m_flush  = id_br_taken && !m_stall;
    m_start  = !m_busy && id_is_md && !m_stall;
    m_fwda   = pick(m_rs_ex, m_rs_mem);
    m_fwdb   = pick(m_rt_ex, m_rt_mem);
  end

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy_left <= 0;
      m_sc      <= 0;
    end else begin
      if (m_start)            busy_left <= id_is_div ? DIV_LAT : MUL_LAT;
      else if (busy_left > 0) busy_left <= busy_left - 1;
      if (m_stall && m_sc != SC_MAX) m_sc <= m_sc + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m.stall",     64'(stall),        64'(m_stall));
    check("m.bubble",    64'(id_ex_bubble), 64'(m_stall));
    check("m.flush",     64'(if_id_flush),  64'(m_flush));
    check("m.fwda",      64'(fwda),         64'(m_fwda));
    check("m.fwdb",      64'(fwdb),         64'(m_fwdb));
    check("m.md_start",  64'(md_start),     64'(m_start));
    check("m.md_busy",   64'(md_busy),      64'(m_busy));
    check("m.stall_cnt", 64'(stall_cnt),    m_sc);
  end

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_is_md = 0; id_is_div = 0; id_rd_hilo = 0; id_br_taken = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.stall",     64'(stall),     64'd0);
    check("rst.md_busy",   64'(md_busy),   64'd0);
    check("rst.stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst.fwda",      64'(fwda),      64'd0);
    #2 clrn = 1'b1;
    step();

    // Load-use: lw $2 in EX, ID reads $2
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 2; id_rs = 2; id_use_rs = 1;
    @(negedge clk);
    check("lu.stall",  64'(stall),        64'd1);
    check("lu.bubble", 64'(id_ex_bubble), 64'd1);
    check("lu.fwda",   64'(fwda),         64'd0);
    step();
    ex_wreg = 0; ex_m2reg = 0; ex_rd = 0; mem_wreg = 1; mem_m2reg = 1; mem_rd = 2;
    @(negedge clk);
    check("lu.fwda_ld",   64'(fwda),      64'd3);
    check("lu.stall_off", 64'(stall),     64'd0);
    check("lu.cnt",       64'(stall_cnt), 64'd1);
    step(); clear_inputs();

    // Forwarding priority and $0
    ex_wreg = 1; ex_rd = 3; mem_wreg = 1; mem_rd = 3; id_rt = 3; id_use_rt = 1;
    @(negedge clk);
    check("fwd.ex", 64'(fwdb), 64'd1);
    step(); ex_rd = 0;
    @(negedge clk);
    check("fwd.mem", 64'(fwdb), 64'd2);
    step(); mem_rd = 0; id_rt = 0;
    @(negedge clk);
    check("fwd.zero", 64'(fwdb), 64'd0);
    step(); clear_inputs();

    // div, then mfhi at busy cycle 5
    id_is_md = 1; id_is_div = 1;
    @(negedge clk);
    check("div.start", 64'(md_start), 64'd1);
    step(); id_is_md = 0; id_is_div = 0;
    @(negedge clk);
    check("div.busy1",   64'(md_busy),  64'd1);
    check("div.nostart", 64'(md_start), 64'd0);
    repeat (4) step();
    id_rd_hilo = 1;
    @(negedge clk);
    check("div.hilo_stall", 64'(stall), 64'd1);
    repeat (11) step();
    @(negedge clk);
    check("div.last_stall", 64'(stall),   64'd1);
    check("div.last_busy",  64'(md_busy), 64'd1);
    step();
    @(negedge clk);
    check("div.done_busy",  64'(md_busy),   64'd0);
    check("div.done_stall", 64'(stall),     64'd0);
    check("div.cnt",        64'(stall_cnt), 64'd13);
    step(); clear_inputs();

    // mult followed by a second mult waiting in ID
    id_is_md = 1;
    @(negedge clk);
    check("mul.start", 64'(md_start), 64'd1);
    step();
    @(negedge clk);
    check("mul.stall2",   64'(stall),    64'd1);
    check("mul.nostart2", 64'(md_start), 64'd0);
    repeat (3) step();
    @(negedge clk);
    check("mul.stall_last", 64'(stall), 64'd1);
    step();
    @(negedge clk);
    check("mul.restart", 64'(md_start),  64'd1);
    check("mul.unstall", 64'(stall),     64'd0);
    check("mul.cnt",     64'(stall_cnt), 64'd17);
    step(); id_is_md = 0;
    repeat (3) step();
    @(negedge clk);
    check("mul.busy4", 64'(md_busy), 64'd1);
    step();
    @(negedge clk);
    check("mul.idle", 64'(md_busy), 64'd0);
    step();

    // Branch flush, suppressed under load-use
    id_br_taken = 1;
    @(negedge clk);
    check("br.flush", 64'(if_id_flush), 64'd1);
    step(); ex_wreg = 1; ex_m2reg = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    @(negedge clk);
    check("br.noflush", 64'(if_id_flush), 64'd0);
    check("br.stall",   64'(stall),       64'd1);
    step(); ex_wreg = 0; ex_m2reg = 0; ex_rd = 0; id_rs = 0; id_use_rs = 0;
    @(negedge clk);
    check("br.flush2", 64'(if_id_flush), 64'd1);
    check("br.cnt",    64'(stall_cnt),   64'd18);
    step(); clear_inputs();

    // Load-use together with mult in ID while idle
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1; id_is_md = 1;
    @(negedge clk);
    check("lumd.stall",   64'(stall),    64'd1);
    check("lumd.nostart", 64'(md_start), 64'd0);
    step(); ex_wreg = 0; ex_m2reg = 0; ex_rd = 0; id_rt = 0; id_use_rt = 0;
    @(negedge clk);
    check("lumd.start", 64'(md_start),  64'd1);
    check("lumd.cnt",   64'(stall_cnt), 64'd19);
    step(); id_is_md = 0;
    repeat (4) step();
    @(negedge clk);
    check("lumd.idle", 64'(md_busy), 64'd0);
    step();

    // Reset during div busy cycle 7
    id_is_md = 1; id_is_div = 1;
    step(); clear_inputs();
    repeat (6) step();
    @(negedge clk);
    check("rstb.busy7", 64'(md_busy), 64'd1);
    #2 clrn = 1'b0;
    #1;
    check("rstb.busy",  64'(md_busy),   64'd0);
    check("rstb.cnt",   64'(stall_cnt), 64'd0);
    check("rstb.start", 64'(md_start),  64'd0);
    repeat (2) step();
    #2 clrn = 1'b1;
    step();
    @(negedge clk);
    check("rstb.nostart", 64'(md_start), 64'd0);
    check("rstb.idle",    64'(md_busy),  64'd0);
    step();
    @(negedge clk);
    check("rstb.idle2", 64'(md_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall scheduler for the 5-stage pipeline. Decides each cycle whether PC and IF/ID hold (stall), whether ID/EX receives a bubble, and whether IF/ID is flushed on a taken branch. It also produces the operand forwarding selects and sequences the shared multi-cycle mult/div unit through a busy state machine. Sits beside the ID stage; its stall output drives the IF/ID register's stall input and the PC write enable.

Parameters:
MUL_LAT, 4, cycles the mult/div unit is busy for mult/multu (1..2^CNT_W-1)
DIV_LAT, 16, cycles the unit is busy for div/divu (1..2^CNT_W-1)
CNT_W, 5, width of the mult/div countdown counter
PC_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
id_rs  in  5  ID-stage rs field
id_rt  in  5  ID-stage rt field
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_is_md  in  1  ID instruction is mult/multu/div/divu
id_is_div  in  1  qualifies id_is_md: 1 = divide
id_rd_hilo  in  1  ID instruction is mfhi/mflo
id_br_taken  in  1  branch/jump resolved taken in ID
ex_wreg  in  1  EX instruction writes the register file
ex_m2reg  in  1  EX instruction is a load
ex_rd  in  5  EX destination register
mem_wreg  in  1  MEM instruction writes the register file
mem_m2reg  in  1  MEM instruction is a load
mem_rd  in  5  MEM destination register
stall  out  1  hold PC and IF/ID
id_ex_bubble  out  1  load a NOP into ID/EX
if_id_flush  out  1  clear IF/ID on the next edge
fwda  out  2  rs operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
fwdb  out  2  rt operand select, same encoding
md_start  out  1  one-cycle start pulse to the mult/div unit
md_busy  out  1  mult/div unit occupied
stall_cnt  out  PC_W  saturating count of stalled cycles

Behaviour:
- Reset (clrn=0, async): state IDLE, md counter 0, stall_cnt 0. md_busy=0. All combinational outputs evaluate to 0 when the inputs are 0.
- Dependence match uses reg!=0: rs_ex = id_use_rs & ex_wreg & ex_rd!=0 & ex_rd==id_rs. rt_ex, rs_mem and rt_mem are defined the same way.
- Load-use hazard lu = ex_m2reg & (rs_ex | rt_ex).
- Structural hazard: sh = md_busy & (id_rd_hilo | id_is_md).
- Combinational outputs, same cycle:
  - stall = lu | sh; id_ex_bubble = stall.
  - if_id_flush = id_br_taken & ~stall. While stalled the branch is re-evaluated next cycle, so a flush is never issued while stalled.
- fwda: 01 if rs_ex & ~ex_m2reg. Else 11 if rs_mem & mem_m2reg. Else 10 if rs_mem. Else 00. EX has priority over MEM. fwdb is the same, using rt.
- Mult/div FSM, states IDLE and BUSY:
  - IDLE: md_start = id_is_md & ~stall. On md_start, cnt <= (id_is_div ? DIV_LAT : MUL_LAT) and go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, next state is IDLE and cnt becomes 0. md_busy = (state==BUSY).
  - md_busy is therefore high for exactly LAT cycles after the start edge.
  - A new mult/div arriving while BUSY stalls (sh). It starts in the first cycle after the FSM returns to IDLE.
  - md_start is never asserted in BUSY.
- Simultaneous lu and mult/div in ID while IDLE: stall wins and md_start=0. The start is issued once the stall clears.
- stall_cnt increments on each rising edge with stall=1 and saturates at all-ones.
- Reset mid-BUSY aborts the operation: IDLE, cnt=0, with no md_start.

Decomposition:
- Shared package: forwarding encodings FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_MEMLD=2'b11; FSM state encodings IDLE/BUSY; register-number width 5.
- One natural sub-module: md_sequencer. It contains the FSM, the countdown counter and md_start/md_busy, and takes stall as an input.
- Hazard and forwarding logic stays in the top level.

Test Plan:
- lw $2 in EX (ex_m2reg=1, ex_wreg=1, ex_rd=2); ID reads rs=2 -> stall=1, id_ex_bubble=1 for 1 cycle, fwda=00. After the load moves to MEM: fwda=11, stall=0, stall_cnt=1.
- ALU write to $3 in EX and to $3 in MEM; ID rt=3 with id_use_rt=1 -> fwdb=01. With ex_rd=0 and mem_rd=3 (mem_wreg=1, mem_m2reg=0) -> fwdb=10. Any write to $0 -> 00.
- div issued (id_is_md=1, id_is_div=1) -> md_start pulse 1 cycle; md_busy=1 for 16 cycles. mfhi in ID at busy cycle 5 -> stall=1 until md_busy falls, then stall=0.
- mult busy (MUL_LAT=4) with a second mult in ID -> stall for the remaining cycles. md_start fires in the first IDLE cycle; md_busy is high 4 more cycles.
- id_br_taken=1 with no hazard -> if_id_flush=1. The same branch with lu=1 -> if_id_flush=0 and stall=1; the next cycle without lu -> flush=1.
- clrn low during div busy cycle 7 -> md_busy=0 and stall_cnt=0 immediately. No md_start after release.
